// File: rtl/fetch_stage.sv
// fetch_stage: PC + imem req/ack fetch into a 2-entry {bundle, pc} FIFO feeding IF/ID; EX redirects flush and drop wrong-path fetches.
// ack -> if_valid one cycle later; stall holds the head; FETCH_PERF_EN adds perf_bundles/perf_starve counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr2Word,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        IF_flush
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_bundles,
  output logic [31:0] perf_starve
`endif
);

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q;
  logic        drop_q, drop_d;
  logic [1:0]  count_q, count_nxt;
  logic        rd_ptr_q, wr_ptr_q;
  logic [31:0] fifo_bun_q [2];
  logic [31:0] fifo_pc_q  [2];
  logic        push, pop;

  assign if_valid   = (count_q != 2'd0);
  assign pop        = if_valid && !stall && !redirect;
  assign push       = (state_q == S_WAIT) && imem_ack && !drop_q && !redirect;
  assign count_nxt  = count_q + {1'b0, push} - {1'b0, pop};
  assign imem_req   = (state_q == S_WAIT);
  // While a wrong-path fetch is still outstanding, keep presenting its address.
  assign imem_addr  = drop_q ? hold_q : pc_q;
  assign instr2Word = if_valid ? fifo_bun_q[rd_ptr_q] : 32'h0;
  assign if_pc      = if_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
  assign IF_flush   = redirect;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (redirect) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = S_WAIT;
      if (state_q == S_WAIT) drop_d = !imem_ack;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_nxt < 2'd2 || drop_q) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_ack) begin
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              pc_d = pc_q + 32'd4;
              // Only re-request when the FIFO can still take the response.
              if (count_nxt == 2'd2) state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_INIT;
      drop_q  <= 1'b0;
      hold_q  <= PC_INIT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      if (redirect && state_q == S_WAIT && !imem_ack && !drop_q) hold_q <= pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      fifo_bun_q[0] <= 32'h0;
      fifo_bun_q[1] <= 32'h0;
      fifo_pc_q[0]  <= 32'h0;
      fifo_pc_q[1]  <= 32'h0;
    end else if (redirect) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_bun_q[wr_ptr_q] <= imem_rdata;
        fifo_pc_q[wr_ptr_q]  <= pc_q;
        wr_ptr_q             <= !wr_ptr_q;
      end
      if (pop) rd_ptr_q <= !rd_ptr_q;
      count_q <= count_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_bundles <= 32'h0;
      perf_starve  <= 32'h0;
    end else begin
      if (pop) perf_bundles <= perf_bundles + 32'd1;
      if (!stall && !redirect && !if_valid) perf_starve <= perf_starve + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

- Instruction-fetch stage of the dual-issue VLIW pipeline.
- Holds the PC and fetches 32-bit bundles from instruction memory through a req/ack handshake. Bundle layout: [31:16] mem slot, [15:0] alu slot.
- Buffers fetched bundles in a 2-entry FIFO and presents the head to the IF/ID pipeline register.
- Handles hazard stalls and branch/jump redirects from EX, discarding wrong-path fetches.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset. Bits [1:0] are ignored and treated as 0.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard stall. When high, IF/ID does not capture and the FIFO head is not popped.
- redirect  in  1  branch/jump taken, from EX.
- redirect_pc  in  32  target PC. Bits [1:0] are forced to 0.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address. Held stable while imem_req=1 and no ack.
- imem_ack  in  1  response strobe. imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched bundle.
- instr2Word  out  32  FIFO head bundle. Forced to 32'h0 (NOP pair) when empty.
- if_pc  out  32  PC of the head bundle. 0 when empty.
- if_valid  out  1  FIFO non-empty.
- IF_flush  out  1  equals redirect (combinational). Clears IF/ID.

## Operation

Registered state:
- pc: next fetch address.
- FIFO: 2 entries, each {bundle, pc}, plus count (0..2).
- drop: 1 bit.
- FSM with states S_IDLE and S_WAIT.

FSM:
- **S_IDLE:** imem_req=0. Moves to S_WAIT when count + (pending pop ? -1 : 0) < 2, or whenever drop is set.
- **S_WAIT:** imem_req=1, imem_addr=pc.
  - On imem_ack with drop=0: push {imem_rdata, pc} into the FIFO and set pc ← pc+4. Then re-request (stay in S_WAIT) if space remains after this cycle's push and pop; otherwise go to S_IDLE.
  - On imem_ack with drop=1: discard the data, clear drop, leave pc unchanged, stay in S_WAIT.
- The FSM never issues a request it cannot later push, so the FIFO never overflows.

Pop:
- A pop occurs when if_valid=1, stall=0 and redirect=0.

Redirect (highest priority):
- FIFO is flushed: count ← 0.
- pc ← {redirect_pc[31:2], 2'b00}.
- If a request is outstanding (S_WAIT) and no ack arrives this cycle, drop ← 1. The address stays stable until the ack, then the FSM re-requests at the new pc.
- If an ack arrives in the same cycle as the redirect, the ack data is discarded and drop stays 0.
- If the FSM is in S_IDLE, it moves to S_WAIT.

Simultaneous events:
- Push and pop in the same cycle: count is unchanged and the head advances.
- Redirect overrides push, pop and stall.
- stall with redirect: the flush still happens.

PC arithmetic:
- pc increments modulo 2^32.
- 32'hFFFF_FFFC + 4 wraps to 0 with no error.

## Timing

Reset values (all outputs):
- pc=RESET_PC, count=0, drop=0, state=S_IDLE.
- imem_req=0, imem_addr=RESET_PC.
- instr2Word=0, if_pc=0, if_valid=0, IF_flush=0.

Sequencing:
- First imem_req=1 appears in the first cycle after reset deasserts.
- An ack at edge N makes if_valid=1 after edge N+1 (registered FIFO). There is no combinational path from imem_rdata to instr2Word.
- A zero-wait memory (ack in every request cycle) sustains 1 bundle/cycle with stall=0.
- Redirect asserted in cycle N: if_valid=0 from N+1. The first request at the target issues in N+1 if no fetch is outstanding; otherwise it follows the dropped ack.
- Reset asserted mid-transaction: all state returns to its reset value immediately (asynchronous). The memory is expected to abandon the transaction.

## Configuration

FETCH_PERF_EN defined:
- Adds outputs perf_bundles (32 bits) and perf_starve (32 bits), both reset to 0 and wrapping.
- perf_bundles increments on each pop.
- perf_starve increments each cycle with stall=0, redirect=0 and if_valid=0.

FETCH_PERF_EN undefined:
- Ports and counters are absent. Behaviour is otherwise identical.

## Test plan

- **Reset and zero-wait stream.** RESET_PC=32'h100, ack every cycle, rdata = address. Expect imem_addr 100,104,108,… on consecutive cycles, and instr2Word/if_pc 100,104,… from the second cycle, one per cycle.
- **Stall fill.** stall=1 for 5 cycles during the stream. Expect count to reach 2, imem_req to drop to 0, and the head to hold 100. After release, bundles 100,104,108 pop in order with none lost or duplicated.
- **Redirect with fetch in flight.** Ack latency 3, redirect_pc=32'h2003 asserted one cycle into a request. Expect imem_addr to hold the old address until its ack and that data to be discarded. Next imem_addr is 32'h2000; the first valid if_pc is 32'h2000; IF_flush=1 only in the redirect cycle.
- **Redirect coincident with ack.** Ack data 32'hDEAD_BEEF arrives in the redirect cycle. Expect it never to appear on instr2Word and the next request to go to the target.
- **PC wrap and async reset.** RESET_PC=32'hFFFF_FFF8. Expect fetches FFF8, FFFC, 0000_0000. Reset pulsed low mid-request expects all outputs at reset values within the same cycle.
- **FETCH_PERF_EN.** 10 pops and 4 empty unstalled cycles. Expect perf_bundles=10 and perf_starve=4.
